// File: rtl/shared_bus_driver_pkg.sv
// Shared definitions for the shared-bus driver: FSM state encoding and a
// width helper used to size the internal counters and pointers.
package shared_bus_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    // Ceiling log2 that never returns less than 1, so a counter that only
    // ever needs to hold 0 still gets a legal one-bit vector.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/shared_bus_driver_rr_arbiter.sv
// Combinational round-robin pick: the first requester found when scanning
// cyclically upward from rr_ptr. Reports whether anyone won, the winner as
// a one-hot vector, and the winner's index.
module shared_bus_driver_rr_arbiter
    import shared_bus_driver_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             any,
    output logic [N_CH-1:0]  winner_oh,
    output logic [PTR_W-1:0] winner_idx
);

    logic             found_s;
    logic             hit_s;
    logic [PTR_W-1:0] cand_s;
    logic [PTR_W-1:0] idx_s;

    // Cyclic priority scan; the first hit latches and later hits are ignored.
    always_comb begin
        found_s = 1'b0;
        hit_s   = 1'b0;
        cand_s  = '0;
        idx_s   = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand_s  = PTR_W'((int'(rr_ptr) + i) % N_CH);
            hit_s   = req[cand_s];
            idx_s   = (!found_s && hit_s) ? cand_s : idx_s;
            found_s = found_s | hit_s;
        end
    end

    assign any        = found_s;
    assign winner_idx = idx_s;
    assign winner_oh  = found_s ? ({{(N_CH-1){1'b0}}, 1'b1} << idx_s) : '0;

endmodule

// File: rtl/shared_bus_driver.sv
// Round-robin owner of a shared bidirectional bus. One channel at a time is
// granted; its drive data and output enable are registered, every release is
// followed by undriven turnaround cycles, and an optional hold limit forces a
// handoff when other channels are waiting. The bus is sampled every cycle.
module shared_bus_driver
    import shared_bus_driver_pkg::*;
#(
    parameter int W           = 16,
    parameter int N_CH        = 4,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_CH-1:0]   req,
    input  logic [N_CH-1:0]   we,
    input  logic [N_CH*W-1:0] wdata,
    output logic [N_CH-1:0]   gnt,
    inout  wire  [W-1:0]      bus,
    output logic              bus_oe,
    output logic [W-1:0]      rdata
);

    localparam int PTR_W  = clog2_min1(N_CH);
    localparam int HOLD_W = clog2_min1(MAX_HOLD + 1);
    localparam int TURN_W = clog2_min1(TURN_CYCLES + 1);

    state_e            state_r,    state_s;
    logic [N_CH-1:0]   gnt_r,      gnt_s;
    logic [PTR_W-1:0]  owner_r,    owner_s;
    logic [PTR_W-1:0]  rr_ptr_r,   rr_ptr_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
    logic [TURN_W-1:0] turn_cnt_r, turn_cnt_s;
    logic              oe_r,       oe_s;
    logic [W-1:0]      out_r,      out_s;
    logic [W-1:0]      rdata_r;

    logic              arb_any_s;
    logic [N_CH-1:0]   arb_oh_s;
    logic [PTR_W-1:0]  arb_idx_s;
    logic              do_grant_s;
    logic              others_s;
    logic              hold_full_s;
    logic              hold_sat_s;
    logic              release_s;
    logic              turn_last_s;

    shared_bus_driver_rr_arbiter #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_arb (
        .req        (req),
        .rr_ptr     (rr_ptr_r),
        .any        (arb_any_s),
        .winner_oh  (arb_oh_s),
        .winner_idx (arb_idx_s)
    );

    // Another channel is waiting while the current owner holds the bus.
    assign others_s    = |(req & ~gnt_r);
    assign hold_full_s = (hold_cnt_r == HOLD_W'(MAX_HOLD));
    // With no limit configured the hold counter simply stops moving.
    assign hold_sat_s  = (MAX_HOLD == 0) | hold_full_s;
    assign release_s   = ~req[owner_r] | ((MAX_HOLD != 0) & hold_full_s & others_s);
    assign turn_last_s = (turn_cnt_r == TURN_W'(TURN_CYCLES));

    // Next-state, grant and drive-register decode for the ownership FSM.
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt_r;
        owner_s    = owner_r;
        rr_ptr_s   = rr_ptr_r;
        hold_cnt_s = hold_cnt_r;
        turn_cnt_s = turn_cnt_r;
        oe_s       = oe_r;
        out_s      = out_r;
        do_grant_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (arb_any_s) begin
                    do_grant_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (release_s) begin
                    state_s    = ST_TURN;
                    gnt_s      = '0;
                    oe_s       = 1'b0;
                    turn_cnt_s = TURN_W'(1);
                end else begin
                    oe_s  = we[owner_r];
                    out_s = wdata[int'(owner_r)*W +: W];
                    if (hold_sat_s) begin
                        hold_cnt_s = hold_cnt_r;
                    end else begin
                        hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                    end
                end
            end
            ST_TURN: begin
                if (turn_last_s) begin
                    if (arb_any_s) begin
                        do_grant_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    turn_cnt_s = turn_cnt_r + TURN_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = '0;
                oe_s    = 1'b0;
            end
        endcase

        // A new owner takes the bus; its data starts driving one edge later.
        if (do_grant_s) begin
            state_s    = ST_DRIVE;
            gnt_s      = arb_oh_s;
            owner_s    = arb_idx_s;
            rr_ptr_s   = (arb_idx_s == PTR_W'(N_CH - 1)) ? '0 : arb_idx_s + PTR_W'(1);
            hold_cnt_s = HOLD_W'(1);
        end else begin
            owner_s = owner_s;
        end
    end

    // State, grant, counters and drive registers; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            gnt_r      <= '0;
            owner_r    <= '0;
            rr_ptr_r   <= '0;
            hold_cnt_r <= '0;
            turn_cnt_r <= '0;
            oe_r       <= 1'b0;
            out_r      <= '0;
        end else begin
            state_r    <= state_s;
            gnt_r      <= gnt_s;
            owner_r    <= owner_s;
            rr_ptr_r   <= rr_ptr_s;
            hold_cnt_r <= hold_cnt_s;
            turn_cnt_r <= turn_cnt_s;
            oe_r       <= oe_s;
            out_r      <= out_s;
        end
    end

    // Read-back register: whatever is on the bus, every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_r <= '0;
        end else begin
            rdata_r <= bus;
        end
    end

    assign bus    = oe_r ? out_r : {W{1'bz}};
    assign gnt    = gnt_r;
    assign bus_oe = oe_r;
    assign rdata  = rdata_r;

endmodule

// File: tb/tb_shared_bus_driver.sv
// Bench for shared_bus_driver: two instances (unlimited hold, hold limit 4)
// share one stimulus; a per-cycle model of the ownership rules checks both,
// and directed sequences pin hand-computed values.
module tb_shared_bus_driver;

    localparam int W = 16;
    localparam int N = 4;
    localparam int TC = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req, we;
    logic [N*W-1:0]   wdata;
    logic             drv_en;
    logic [W-1:0]     drv_val;
    logic [N-1:0]     gnt0, gnt4;
    logic             oe0, oe4;
    logic [W-1:0]     rdata0, rdata4;
    wire  [W-1:0]     bus0, bus4;

    int n_tests = 0;
    int n_fail  = 0;

    assign bus0 = drv_en ? drv_val : {W{1'bz}};
    assign bus4 = drv_en ? drv_val : {W{1'bz}};

    shared_bus_driver #(.W(W), .N_CH(N), .TURN_CYCLES(TC), .MAX_HOLD(0)) u_dut0 (
        .clock(clk), .reset(reset), .req(req), .we(we), .wdata(wdata),
        .gnt(gnt0), .bus(bus0), .bus_oe(oe0), .rdata(rdata0));

    shared_bus_driver #(.W(W), .N_CH(N), .TURN_CYCLES(TC), .MAX_HOLD(4)) u_dut4 (
        .clock(clk), .reset(reset), .req(req), .we(we), .wdata(wdata),
        .gnt(gnt4), .bus(bus4), .bus_oe(oe4), .rdata(rdata4));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        int          owner;      // -1: nobody owns the bus
        int          turn_left;  // undriven cycles still owed
        int          held;       // grant cycles so far
        int          ptr;        // highest-priority channel
        logic        oe;
        logic [W-1:0] out;
        logic [W-1:0] rdata;
        logic        rdata_ok;   // bus was actively driven when sampled
    } mst_t;

    function automatic mst_t mstep(mst_t s, int maxh, logic rst, logic [N-1:0] rq,
                                   logic [N-1:0] wq, logic [N*W-1:0] wd,
                                   logic de, logic [W-1:0] dv);
        mst_t n;
        int   others;
        n = s;
        if (s.oe) begin
            n.rdata = s.out; n.rdata_ok = 1'b1;
        end else if (de) begin
            n.rdata = dv; n.rdata_ok = 1'b1;
        end else begin
            n.rdata_ok = 1'b0;
        end
        if (rst) begin
            n.owner = -1; n.turn_left = 0; n.held = 0; n.ptr = 0;
            n.oe = 1'b0; n.out = '0; n.rdata = '0; n.rdata_ok = 1'b1;
            return n;
        end
        if (s.owner >= 0) begin
            others = 0;
            for (int c = 0; c < N; c++) if (c != s.owner && rq[c]) others = 1;
            if (!rq[s.owner] || (maxh != 0 && s.held >= maxh && others != 0)) begin
                n.owner = -1; n.turn_left = TC; n.oe = 1'b0;
            end else begin
                n.oe = wq[s.owner]; n.out = wd[s.owner*W +: W]; n.held = s.held + 1;
            end
            return n;
        end
        if (s.turn_left > 0) begin
            n.turn_left = s.turn_left - 1;
            if (n.turn_left > 0) return n;
        end
        for (int k = 0; k < N; k++) begin
            int c;
            c = (s.ptr + k) % N;
            if (rq[c]) begin
                n.owner = c; n.held = 1; n.ptr = (c + 1) % N;
                return n;
            end
        end
        return n;
    endfunction

    mst_t m0, m4;
    logic mvalid = 1'b0;

    always @(posedge clk) begin
        m0 <= mstep(m0, 0, reset, req, we, wdata, drv_en, drv_val);
        m4 <= mstep(m4, 4, reset, req, we, wdata, drv_en, drv_val);
        if (reset) mvalid <= 1'b1;
    end

    function automatic logic [N-1:0] exp_gnt(mst_t s);
        return (s.owner >= 0) ? (N'(1) << s.owner) : '0;
    endfunction

    logic [N-1:0] pg0 = '0, pg4 = '0;
    logic         po0 = 1'b0, po4 = 1'b0;

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("m0_gnt", gnt0, exp_gnt(m0));
            chk("m0_oe", oe0, m0.oe);
            if (m0.oe) chk("m0_bus", bus0, m0.out);
            if (m0.rdata_ok) chk("m0_rdata", rdata0, m0.rdata);
            chk("m4_gnt", gnt4, exp_gnt(m4));
            chk("m4_oe", oe4, m4.oe);
            if (m4.oe) chk("m4_bus", bus4, m4.out);
            if (m4.rdata_ok) chk("m4_rdata", rdata4, m4.rdata);
            chk("onehot0_gnt0", $onehot0(gnt0), 1'b1);
            chk("onehot0_gnt4", $onehot0(gnt4), 1'b1);
            if (oe0 && po0) chk("adj_drive0", gnt0, pg0);
            if (oe4 && po4) chk("adj_drive4", gnt4, pg4);
            if (oe0) chk("oe_has_owner0", (gnt0 != '0), 1'b1);
            if (oe4) chk("oe_has_owner4", (gnt4 != '0), 1'b1);
        end
        pg0 <= gnt0; po0 <= oe0;
        pg4 <= gnt4; po4 <= oe4;
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_gnt(input int which, input logic [N-1:0] tgt, input int budget,
                            output int waited);
        waited = 0;
        while (((which == 4) ? gnt4 : gnt0) !== tgt && waited < budget) begin
            cyc(1);
            waited++;
        end
        chk("gnt_arrive", (which == 4) ? gnt4 : gnt0, tgt);
    endtask

    logic [N-1:0] exp4 [11];
    int           waited;

    initial begin
        exp4 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001};
        reset = 1'b1; req = '0; we = '0; wdata = '0; drv_en = 1'b0; drv_val = '0;
        cyc(2);
        chk("rst_gnt0", gnt0, 4'b0000);
        chk("rst_gnt4", gnt4, 4'b0000);
        chk("rst_oe4", oe4, 1'b0);
        chk("rst_rdata4", rdata4, 16'h0000);
        reset = 1'b0;

        // single requester: grant after 1 cycle, bus one cycle later
        req = 4'b0010; we = 4'b0010; wdata[1*W +: W] = 16'h1234;
        cyc(1);
        chk("t2_gnt", gnt4, 4'b0010);
        chk("t2_oe_lag", oe4, 1'b0);
        cyc(1);
        chk("t2_bus", bus4, 16'h1234);
        chk("t2_oe", oe4, 1'b1);

        // reset while ch1 drives 0x00A5
        wdata[1*W +: W] = 16'h00A5;
        cyc(2);
        chk("t1_bus_pre", bus4, 16'h00A5);
        chk("t1_rdata_pre", rdata4, 16'h00A5);
        reset = 1'b1;
        cyc(1);
        chk("t1_gnt", gnt4, 4'b0000);
        chk("t1_oe", oe4, 1'b0);
        chk("t1_rdata", rdata4, 16'h0000);
        reset = 1'b0;

        // all four request; each drops after three grant cycles
        req = 4'b1111; we = 4'b1111;
        wdata = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
        for (int c = 0; c < N; c++) begin
            wait_gnt(0, N'(1) << c, 6, waited);
            chk("t3_wait", waited, 1);
            cyc(1);
            chk("t3_bus", bus0, wdata[c*W +: W]);
            cyc(1);
            req[c] = 1'b0;
            cyc(1);
            chk("t3_turn_gnt", gnt0, 4'b0000);
            chk("t3_turn_oe", oe0, 1'b0);
        end
        cyc(3);

        // hold limit 4 with ch0 and ch2 competing
        req = 4'b0101; we = 4'b0101;
        wdata[0 +: W] = 16'hA000; wdata[2*W +: W] = 16'hA002;
        for (int k = 0; k < 11; k++) begin
            cyc(1);
            chk("t4_gnt", gnt4, exp4[k]);
            if (k == 1) chk("t4_bus", bus4, 16'hA000);
        end
        req = '0;
        cyc(4);

        // lone requester keeps the bus past the hold limit
        req = 4'b1000; we = 4'b1000; wdata[3*W +: W] = 16'h5A5A;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            chk("t5_gnt", gnt4, 4'b1000);
            if (k >= 2) chk("t5_oe", oe4, 1'b1);
        end
        req = '0;
        cyc(4);

        // owner reads while the bench drives the bus, then toggles we
        req = 4'b0001; we = 4'b0000; drv_en = 1'b1; drv_val = 16'hBEEF;
        cyc(1);
        chk("t6_gnt", gnt4, 4'b0001);
        cyc(1);
        chk("t6_oe", oe4, 1'b0);
        chk("t6_rdata", rdata4, 16'hBEEF);
        drv_en = 1'b0; we = 4'b0001; wdata[0 +: W] = 16'h0F0F;
        cyc(1);
        chk("t6_we_oe", oe4, 1'b1);
        chk("t6_we_bus", bus4, 16'h0F0F);
        we = 4'b0000;
        cyc(1);
        chk("t6_we_off_oe", oe4, 1'b0);
        chk("t6_we_off_gnt", gnt4, 4'b0001);
        req = '0;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
